// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO
// register pair. It takes one shift-add or restoring-divide step per cycle,
// applies sign fix-up in a final cycle, then commits HI/LO and pulses done.
// The HI/LO read port is combinational and feeds writeback mux operand C.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    // Two's-complement negate when neg is set (operand magnitude / fix-up).
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    // Double-width variant used for the full product.
    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? (~v + ONE_2W) : v;
    endfunction

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;      // product / quotient must be negated
    logic               neg_r;      // remainder must be negated (sign of a)
    logic               div_zero;   // divisor was zero at launch
    logic [WIDTH-1:0]   a_raw;      // dividend as sampled, for divide-by-zero HI
    logic [WIDTH-1:0]   opnd;       // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] acc;        // {HI-side, LO-side} working register
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done_r;

    // Launch-time decode of the incoming operands.
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Magnitudes and sign flags of the operands presented with start.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = neg_if(a, a_neg);
        b_mag     = neg_if(b, b_neg);
    end

    // One iteration step for either algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    // Shift-add multiply step and restoring divide step on acc.
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the whole pair right.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the partial remainder,
        // subtract the divisor if it fits and record the quotient bit in LSB.
        div_part  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_part - {1'b0, opnd};
        div_ge    = (div_part >= {1'b0, opnd});
        if (div_ge) begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign-corrected results committed at the end of FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_new;
    logic [WIDTH-1:0]   lo_new;

    // Final HI/LO values, including divide-by-zero override.
    always_comb begin
        prod_fix = neg2_if(acc, neg_q);
        if (!is_div) begin
            hi_new = prod_fix[2*WIDTH-1:WIDTH];
            lo_new = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            hi_new = a_raw;
            lo_new = {WIDTH{1'b1}};
        end else begin
            hi_new = neg_if(acc[2*WIDTH-1:WIDTH], neg_r);
            lo_new = neg_if(acc[WIDTH-1:0], neg_q);
        end
    end

    // Control FSM, iteration datapath and HI/LO register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (b == {WIDTH{1'b0}});
                        a_raw    <= a;
                        cnt      <= CNT_LOAD;
                        if (op[1]) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                        state <= S_CALC;
                    end else if (mt_we) begin
                        if (mt_sel) begin
                            hi <= mt_data;
                        end else begin
                            lo <= mt_data;
                        end
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi     <= hi_new;
                    lo     <= lo_new;
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs: committed HI/LO read port and status.
    always_comb begin
        rd_data = rd_sel ? hi : lo;
        busy    = (state != S_IDLE);
        done    = done_r;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_data;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mt_we   (mt_we),
        .mt_sel  (mt_sel),
        .mt_data (mt_data),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait for done; returns observations only.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt,
                         output logic [31:0] rhi, output logic [31:0] rlo,
                         output logic dbusy);
        bit got;
        got  = 0;
        lat  = 0;
        bcnt = 0;
        rhi  = '0;
        rlo  = '0;
        dbusy = 1'b1;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            if (i > 1) tick();
            if (done) begin
                got = 1;
                lat = i;
                dbusy = busy;
                rd_sel = 1'b0; #1 rlo = rd_data;
                rd_sel = 1'b1; #1 rhi = rd_data;
                rd_sel = 1'b0;
            end else if (busy) begin
                bcnt++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        rd_sel = 1'b0; #1;
        n_cmp++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 00000000", rd_data); end
        rd_sel = 1'b1; #1;
        n_cmp++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 00000000", rd_data); end
        rd_sel = 1'b0;
    endtask

    task automatic test_mult;
        int lat, bc; logic [31:0] h, l; logic db;
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bc, h, l, db);
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency got %0d want 34", lat); end
        n_cmp++; if (bc !== 33) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (db !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done got %0b want 0", db); end
        n_cmp++; if (h !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", h); end
        n_cmp++; if (l !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got %h want fffffff1", l); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got %0b want 0", done); end
    endtask

    task automatic test_multu;
        int lat, bc; logic [31:0] h, l; logic db;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, h, l, db);
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL multu_latency got %0d want 34", lat); end
        n_cmp++; if (h !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", h); end
        n_cmp++; if (l !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", l); end
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, h, l, db);
        n_cmp++; if (h !== 32'h0) begin n_fail++; $display("FAIL mult_m1_hi got %h want 00000000", h); end
        n_cmp++; if (l !== 32'h1) begin n_fail++; $display("FAIL mult_m1_lo got %h want 00000001", l); end
        tick();
    endtask

    task automatic test_div;
        int lat, bc; logic [31:0] h, l; logic db;
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc, h, l, db);
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
        n_cmp++; if (l !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_quot got %h want fffffffd", l); end
        n_cmp++; if (h !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_rem got %h want ffffffff", h); end
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, h, l, db);
        n_cmp++; if (l !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_quot got %h want 80000000", l); end
        n_cmp++; if (h !== 32'h0) begin n_fail++; $display("FAIL div_ovf_rem got %h want 00000000", h); end
        tick();
    endtask

    task automatic test_div_zero;
        int lat, bc; logic [31:0] h, l; logic db;
        do_op(2'b11, 32'd100, 32'd0, lat, bc, h, l, db);
        n_cmp++; if (l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo got %h want ffffffff", l); end
        n_cmp++; if (h !== 32'h0000_0064) begin n_fail++; $display("FAIL divu0_hi got %h want 00000064", h); end
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat, bc, h, l, db);
        n_cmp++; if (l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo got %h want ffffffff", l); end
        n_cmp++; if (h !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL div0_hi got %h want fffffff9", h); end
        tick();
    endtask

    task automatic test_back_to_back;
        int lat, bc; logic [31:0] h, l; logic db;
        do_op(2'b11, 32'd100, 32'd7, lat, bc, h, l, db);
        n_cmp++; if (l !== 32'd14) begin n_fail++; $display("FAIL b2b_divu_quot got %h want 0000000e", l); end
        n_cmp++; if (h !== 32'd2) begin n_fail++; $display("FAIL b2b_divu_rem got %h want 00000002", h); end
        // Second launch in the done cycle of the first.
        do_op(2'b01, 32'd9, 32'd11, lat, bc, h, l, db);
        n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", lat); end
        n_cmp++; if (l !== 32'd99) begin n_fail++; $display("FAIL b2b_multu_lo got %h want 00000063", l); end
        n_cmp++; if (h !== 32'd0) begin n_fail++; $display("FAIL b2b_multu_hi got %h want 00000000", h); end
        tick();
    endtask

    task automatic test_ignore_while_busy;
        int dcount, dcycle, bc;
        logic [31:0] h, l;
        dcount = 0; dcycle = 0; bc = 0; h = '0; l = '0;
        // Preload HI/LO through the MT port.
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_1111; tick();
        mt_sel = 1'b1; mt_data = 32'h0000_2222; tick();
        mt_we = 1'b0;
        rd_sel = 1'b0; #1;
        n_cmp++; if (rd_data !== 32'h0000_1111) begin n_fail++; $display("FAIL mtlo_write got %h want 00001111", rd_data); end
        // Launch MULTU 7*6 with a competing MT write in the same cycle.
        op = 2'b01; a = 32'd7; b = 32'd6; start = 1'b1;
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h0000_5555;
        tick();
        start = 1'b0; mt_we = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 5);
            if (c == 5) begin op = 2'b00; a = 32'd3; b = 32'd3; end
            mt_we = (c == 10); mt_sel = 1'b0; mt_data = 32'h0000_1234;
            if (busy) bc++;
            if (c == 20) begin
                rd_sel = 1'b0; #1;
                n_cmp++; if (rd_data !== 32'h0000_1111) begin n_fail++; $display("FAIL busy_old_lo got %h want 00001111", rd_data); end
                rd_sel = 1'b1; #1;
                n_cmp++; if (rd_data !== 32'h0000_2222) begin n_fail++; $display("FAIL busy_old_hi got %h want 00002222", rd_data); end
                rd_sel = 1'b0;
            end
            if (done) begin
                dcount++;
                dcycle = c;
                rd_sel = 1'b0; #1 l = rd_data;
                rd_sel = 1'b1; #1 h = rd_data;
                rd_sel = 1'b0;
            end
            tick();
        end
        start = 1'b0; mt_we = 1'b0;
        n_cmp++; if (dcount !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dcount); end
        n_cmp++; if (dcycle !== 34) begin n_fail++; $display("FAIL ignore_done_cycle got %0d want 34", dcycle); end
        n_cmp++; if (bc !== 33) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (l !== 32'd42) begin n_fail++; $display("FAIL ignore_lo got %h want 0000002a", l); end
        n_cmp++; if (h !== 32'd0) begin n_fail++; $display("FAIL ignore_hi got %h want 00000000", h); end
    endtask

    task automatic test_reset_mid_op;
        int dcount;
        logic bsy11;
        logic [31:0] l11, h11;
        dcount = 0; bsy11 = 1'b1; l11 = '1; h11 = '1;
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            reset = (c == 10);
            if (c == 11) begin
                bsy11 = busy;
                rd_sel = 1'b0; #1 l11 = rd_data;
                rd_sel = 1'b1; #1 h11 = rd_data;
                rd_sel = 1'b0;
            end
            if (done) dcount++;
            tick();
        end
        reset = 1'b0;
        n_cmp++; if (bsy11 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", bsy11); end
        n_cmp++; if (l11 !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo got %h want 00000000", l11); end
        n_cmp++; if (h11 !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi got %h want 00000000", h11); end
        n_cmp++; if (dcount !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", dcount); end
        // MTHI after reset: visible the cycle after the strobe.
        mt_we = 1'b1; mt_sel = 1'b1; mt_data = 32'hCAFE_F00D; rd_sel = 1'b1; #1;
        n_cmp++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mthi_early got %h want 00000000", rd_data); end
        tick();
        mt_we = 1'b0;
        n_cmp++; if (rd_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mthi_write got %h want cafef00d", rd_data); end
        rd_sel = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0; rd_sel = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_ignore_while_busy();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU into the HI/LO register pair and supports MTHI/MTLO writes. It drives the HI/LO read result onto operand C of the three-input writeback select mux, which produces MFHI/MFLO results. The pipeline stalls on `busy`; the unit never stalls itself.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- mt_we  input  1  MTHI/MTLO write strobe.
- mt_sel  input  1  0 writes LO, 1 writes HI.
- mt_data  input  WIDTH  MTHI/MTLO data.
- rd_sel  input  1  0 reads LO, 1 reads HI.
- rd_data  output  WIDTH  combinational read of the HI or LO register; feeds writeback mux operand C.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO updated.

## Operation
- States:
  - IDLE, then CALC (WIDTH cycles), then FIX (1 cycle), then back to IDLE.
- IDLE with start=1:
  - latch op.
  - Signed ops latch |a| and |b|; unsigned ops latch the raw values.
  - Record sign flags and load counter = WIDTH-1.
  - Go to CALC.
- CALC, multiply: one shift-add step per cycle on a 2*WIDTH-bit accumulator.
- CALC, divide: one restoring step per cycle. This yields a WIDTH-bit quotient and remainder.
- CALC exits to FIX when counter = 0.
- FIX:
  - apply sign correction: product negated if sign(a)^sign(b); quotient negated if sign(a)^sign(b); remainder takes sign of a.
  - HI/LO written on exit.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (b == 0, DIV or DIVU): LO = all ones, HI = a as sampled (raw, no sign correction).
- DIV of most-negative by -1: LO = 1 followed by WIDTH-1 zeros, HI = 0. No trap.
- mt_we in IDLE with start=0: the selected register is written on that edge.
- mt_we while busy, or in the same cycle as an accepted start: dropped.
- start while busy: ignored; no queueing.
- rd_data always reflects the committed HI/LO. During busy it returns the pre-operation values.
- reset (any state, including mid-CALC/FIX):
  - next cycle is IDLE.
  - HI = LO = 0, busy = 0, done = 0.
  - Counter and accumulator cleared.
  - The in-flight result is discarded; no done pulse.

## Timing
- Reset values: busy 0, done 0, HI 0, LO 0, so rd_data reads 0.
- start accepted in cycle t:
  - busy = 1 in cycles t+1 through t+WIDTH+1.
  - done = 1 and busy = 0 in cycle t+WIDTH+2.
  - Latency is WIDTH+2 cycles (34 for WIDTH=32).
- New HI/LO are visible on rd_data in the done cycle.
- A new start is accepted in the done cycle; back-to-back throughput is one operation per WIDTH+2 cycles.
- done is registered and never coincides with busy.
- An MT write becomes visible on rd_data in the cycle after mt_we.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (-3), b=5, rd_sel toggled in the done cycle -> done at t+34; HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Repeat as MULT -> HI=0, LO=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV a=-7, b=0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- Start MULTU 7*6 in cycle t, pulse start again in t+5 with different operands, assert mt_we (LO=0x1234) in t+10 -> single done at t+34; LO=42, HI=0, so the second start and the MT write are ignored. rd_data during busy returns the old values.
- Start DIVU, assert reset in t+10 -> busy=0 in t+11, HI=LO=0, no done pulse through t+40. Then MTHI 0xCAFEF00D, rd_sel=1 -> rd_data=0xCAFEF00D the next cycle.
